// File: rtl/fetch_seq_if.sv
// Handshake bundle between the fetch sequencer, the execute stage and the program ROM.
// master: the sequencer side. slave: the execute/debug controller side.
interface fetch_seq_if #(
  parameter int ADDR_W = 12
);
  logic              run;
  logic              exec_done;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt_req;
  logic [ADDR_W-1:0] bkpt_addr;
  logic              bkpt_arm;
  logic [ADDR_W-1:0] pc;
  logic              rom_en;
  logic              enabled_fetch;
  logic              instr_valid;
  logic              halted;
  logic              bkpt_hit;

  modport master (
    input  run, exec_done, jump_req, jump_addr, halt_req, bkpt_addr, bkpt_arm,
    output pc, rom_en, enabled_fetch, instr_valid, halted, bkpt_hit
  );

  modport slave (
    output run, exec_done, jump_req, jump_addr, halt_req, bkpt_addr, bkpt_arm,
    input  pc, rom_en, enabled_fetch, instr_valid, halted, bkpt_hit
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: owns pc and the ROM read strobe, pulses the fetch-register load.
// Optional breakpoint comparator enabled by defining FETCH_SEQ_BKPT_EN.
module fetch_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  fetch_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, EXEC, HALT} state_t;

  localparam int CNT_W = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halt_pend_q, halt_pend_d;
  logic              bkpt_hit_q, bkpt_hit_d;
  logic              bkpt_skip_q, bkpt_skip_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              bkpt_stop;

`ifdef FETCH_SEQ_BKPT_EN
  // The skip flag lets a resumed fetch read the breakpoint address once.
  assign bkpt_stop   = (state_q == ADDR) && bus.bkpt_arm && (pc_q == bus.bkpt_addr) && !bkpt_skip_q;
  assign bus.bkpt_hit = bkpt_hit_q;
`else
  logic unused_bkpt;
  assign unused_bkpt  = bus.bkpt_arm ^ (^bus.bkpt_addr);
  assign bkpt_stop    = 1'b0;
  assign bus.bkpt_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halt_pend_d = halt_pend_q;
    bkpt_hit_d  = bkpt_hit_q;
    bkpt_skip_d = bkpt_skip_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.halt_req)  state_d = HALT;
        else if (bus.run)  state_d = ADDR;
      end
      ADDR: begin
        halt_pend_d = halt_pend_q | bus.halt_req;
        bkpt_skip_d = 1'b0;
        if (bkpt_stop) begin
          state_d    = HALT;
          bkpt_hit_d = 1'b1;
        end else if (ROM_LAT > 1) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d    = LATCH;
        end
      end
      WAIT: begin
        halt_pend_d = halt_pend_q | bus.halt_req;
        if (wait_cnt_q == WAIT_LAST) state_d = LATCH;
        else                         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      LATCH: begin
        halt_pend_d = halt_pend_q | bus.halt_req;
        pc_d        = pc_q + ADDR_W'(1);
        state_d     = EXEC;
      end
      EXEC: begin
        if (bus.exec_done) begin
          if (bus.jump_req) pc_d = bus.jump_addr;
          state_d = (halt_pend_q || bus.halt_req) ? HALT : ADDR;
        end else begin
          halt_pend_d = halt_pend_q | bus.halt_req;
        end
      end
      HALT: begin
        if (bus.run && !bus.halt_req) begin
          state_d     = ADDR;
          halt_pend_d = 1'b0;
          bkpt_skip_d = bkpt_hit_q;
          bkpt_hit_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      halt_pend_q <= 1'b0;
      bkpt_hit_q  <= 1'b0;
      bkpt_skip_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_pend_q <= halt_pend_d;
      bkpt_hit_q  <= bkpt_hit_d;
      bkpt_skip_q <= bkpt_skip_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.rom_en        = (state_q == ADDR) && !bkpt_stop;
  assign bus.enabled_fetch = (state_q == LATCH);
  assign bus.instr_valid   = (state_q == EXEC);
  assign bus.halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (ROM_LAT 1 and 3) share stimulus and are
// compared every cycle against a cycle-count reference model, plus vector table and corner sequences.
module tb_fetch_sequencer;

  localparam int ADDR_W = 12;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic              exec_done = 1'b0;
  logic              jump_req = 1'b0;
  logic              halt_req = 1'b0;
  logic              bkpt_arm = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic [ADDR_W-1:0] bkpt_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  fetch_seq_if #(.ADDR_W(ADDR_W)) bus1 ();
  fetch_seq_if #(.ADDR_W(ADDR_W)) bus3 ();

  assign bus1.run = run;       assign bus3.run = run;
  assign bus1.exec_done = exec_done; assign bus3.exec_done = exec_done;
  assign bus1.jump_req = jump_req;   assign bus3.jump_req = jump_req;
  assign bus1.jump_addr = jump_addr; assign bus3.jump_addr = jump_addr;
  assign bus1.halt_req = halt_req;   assign bus3.halt_req = halt_req;
  assign bus1.bkpt_addr = bkpt_addr; assign bus3.bkpt_addr = bkpt_addr;
  assign bus1.bkpt_arm = bkpt_arm;   assign bus3.bkpt_arm = bkpt_arm;

  fetch_sequencer #(.ADDR_W(ADDR_W), .ROM_LAT(LAT0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  fetch_sequencer #(.ADDR_W(ADDR_W), .ROM_LAT(LAT1)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  // Observed outputs per instance; flags are {rom_en, enabled_fetch, instr_valid, halted, bkpt_hit}.
  logic [ADDR_W-1:0] d_pc [2];
  logic [4:0]        d_fl [2];
  assign d_pc[0] = bus1.pc;
  assign d_pc[1] = bus3.pc;
  assign d_fl[0] = {bus1.rom_en, bus1.enabled_fetch, bus1.instr_valid, bus1.halted, bus1.bkpt_hit};
  assign d_fl[1] = {bus3.rom_en, bus3.enabled_fetch, bus3.instr_valid, bus3.halted, bus3.bkpt_hit};

  // Reference model: a fetch is "age" cycles old; the read strobe is age 0, the load is age == latency.
  typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT} mmode_t;
  mmode_t            m_mode [2];
  int                m_age  [2];
  logic [ADDR_W-1:0] m_pc   [2];
  bit                m_pend [2];
  bit                m_hit  [2];
  bit                m_skip [2];

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit bk_fire(input int i);
`ifdef FETCH_SEQ_BKPT_EN
    return (m_mode[i] == M_FETCH) && (m_age[i] == 0) && bkpt_arm && (m_pc[i] == bkpt_addr) && !m_skip[i];
`else
    return (i < 0);
`endif
  endfunction

  function automatic logic [4:0] exp_flags(input int i);
    return {(m_mode[i] == M_FETCH) && (m_age[i] == 0) && !bk_fire(i),
            (m_mode[i] == M_FETCH) && (m_age[i] == lat(i)),
            m_mode[i] == M_EXEC, m_mode[i] == M_HALT, m_hit[i]};
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit fire;
      fire = bk_fire(i);
      if (reset) begin
        m_mode[i] = M_IDLE; m_age[i] = 0; m_pc[i] = '0;
        m_pend[i] = 1'b0; m_hit[i] = 1'b0; m_skip[i] = 1'b0;
      end else begin
        case (m_mode[i])
          M_IDLE: begin
            if (halt_req) m_mode[i] = M_HALT;
            else if (run) begin m_mode[i] = M_FETCH; m_age[i] = 0; end
          end
          M_FETCH: begin
            if (halt_req) m_pend[i] = 1'b1;
            if (m_age[i] == 0) m_skip[i] = 1'b0;
            if (fire) begin
              m_mode[i] = M_HALT; m_hit[i] = 1'b1;
            end else if (m_age[i] == lat(i)) begin
              m_pc[i] = m_pc[i] + 12'd1; m_mode[i] = M_EXEC;
            end else begin
              m_age[i] = m_age[i] + 1;
            end
          end
          M_EXEC: begin
            if (exec_done) begin
              if (jump_req) m_pc[i] = jump_addr;
              if (m_pend[i] || halt_req) m_mode[i] = M_HALT;
              else begin m_mode[i] = M_FETCH; m_age[i] = 0; end
            end else if (halt_req) begin
              m_pend[i] = 1'b1;
            end
          end
          default: begin
            if (run && !halt_req) begin
              m_mode[i] = M_FETCH; m_age[i] = 0; m_pend[i] = 1'b0;
              m_skip[i] = m_hit[i]; m_hit[i] = 1'b0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic r, input logic done,
                               input logic jmp, input logic [ADDR_W-1:0] ja, input logic hlt);
    reset = rst; run = r; exec_done = done; jump_req = jmp; jump_addr = ja; halt_req = hlt;
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then compare just after the edge.
  task automatic cycle();
    if (reset) started = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("model_pc_inst%0d", i), d_pc[i], m_pc[i]);
        checkOutput($sformatf("model_flags_inst%0d", i), 12'(d_fl[i]), 12'(exp_flags(i)));
      end
    end
  endtask

  task automatic wait_flag(input int i, input int bitpos, input string name);
    int n = 0;
    while (d_fl[i][bitpos] !== 1'b1 && n < 32) begin
      cycle();
      n++;
    end
    checkOutput(name, 12'(d_fl[i][bitpos]), 12'd1);
  endtask

  typedef struct packed {
    logic              rst, run, done, jump, halt;
    logic [ADDR_W-1:0] jaddr;
    logic [ADDR_W-1:0] epc;
    logic [4:0]        efl;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // ROM_LAT=1 instance: fetch 0..3 at a 4-cycle rhythm, then jump from the instruction at 3.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 5'b00000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 5'b10000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 5'b01000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 5'b00100};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 5'b00100};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h001, 5'b10000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 5'b01000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 5'b00100};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 5'b00100};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h002, 5'b10000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 5'b01000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h003, 5'b00100};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h003, 5'b00100};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h003, 5'b10000};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h003, 5'b01000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 5'b00100};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 5'b00100};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0A5, 12'h0A5, 5'b10000};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h0A5, 5'b01000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h0A6, 5'b00100};

    #2;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].done, vecs[i].jump, vecs[i].jaddr, vecs[i].halt);
      cycle();
      checkOutput($sformatf("vec%0d_pc", i), bus1.pc, vecs[i].epc);
      checkOutput($sformatf("vec%0d_flags", i), 12'(d_fl[0]), 12'(vecs[i].efl));
    end

    // halt_req while the ROM_LAT=3 instance is in WAIT; run drops mid-fetch.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t3_addr_rom_en", 12'(bus3.rom_en), 12'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1); cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    wait_flag(1, 2, "t3_reach_exec");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t3_halted", 12'(bus3.halted), 12'd1);
    checkOutput("t3_pc_after_halt", bus3.pc, 12'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    repeat (3) cycle();
    checkOutput("t3_pc_held", bus3.pc, 12'h001);
    checkOutput("t3_still_halted", 12'(bus3.halted), 12'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t3_resume_rom_en", 12'(bus3.rom_en), 12'd1);
    checkOutput("t3_resume_pc", bus3.pc, 12'h001);

    // pc wrap at 0xFFF, then jump and halt together (ROM_LAT=1 instance).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    wait_flag(0, 2, "t4_reach_exec");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0); cycle();
    checkOutput("t4_jump_pc", bus1.pc, 12'hFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle(); cycle();
    checkOutput("t4_wrap_pc", bus1.pc, 12'h000);
    checkOutput("t4_wrap_exec", 12'(bus1.instr_valid), 12'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b1); cycle();
    checkOutput("t4_jump_halt_pc", bus1.pc, 12'h123);
    checkOutput("t4_jump_halt_halted", 12'(bus1.halted), 12'd1);

    // reset during WAIT (ROM_LAT=3) and during EXEC (ROM_LAT=1).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t5_wait_reset_pc", bus3.pc, 12'h000);
    checkOutput("t5_wait_reset_flags", 12'(d_fl[1]), 12'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle(); cycle();
    checkOutput("t5_in_exec", 12'(bus1.instr_valid), 12'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t5_exec_reset_pc", bus1.pc, 12'h000);
    checkOutput("t5_exec_reset_flags", 12'(d_fl[0]), 12'd0);

`ifdef FETCH_SEQ_BKPT_EN
    // breakpoint at 2: halt without a read, then resume re-fetches 2.
    bkpt_addr = 12'h002; bkpt_arm = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    wait_flag(0, 1, "t6_reach_halt");
    checkOutput("t6_bkpt_pc", bus1.pc, 12'h002);
    checkOutput("t6_bkpt_hit", 12'(bus1.bkpt_hit), 12'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0); cycle();
    checkOutput("t6_resume_rom_en", 12'(bus1.rom_en), 12'd1);
    checkOutput("t6_resume_pc", bus1.pc, 12'h002);
    checkOutput("t6_hit_cleared", 12'(bus1.bkpt_hit), 12'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0); cycle(); cycle();
    checkOutput("t6_after_pc", bus1.pc, 12'h003);
    bkpt_arm = 1'b0;
`endif

    // Randomized run against the model; small jump targets plus the wrap region.
    for (int c = 0; c < 1500; c++) begin
      logic [ADDR_W-1:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFFE + 12'($urandom_range(0, 1)))
                                       : ADDR_W'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), ja,
                    $urandom_range(0, 15) == 0);
      bkpt_arm  = 1'($urandom_range(0, 1));
      bkpt_addr = ADDR_W'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
